decoder_3to8_stream: RTL and testbench
======================================

// Module: decoder_3to8_stream
// PURPOSE
//  Registered 3-to-8 one-hot decoder with a valid/ready stream on both sides.
//  It is the inverse of the team's 8-to-3 one-hot encoder: it turns an index
//  back into a one-hot select for downstream enable and mux logic.
//  A 2-entry skid buffer keeps full throughput under backpressure.
//  A saturating counter records how many non-zero selects were delivered.
// PARAMETERS
//  SEL_W  3           index width; OUT_W = 1<<SEL_W (8 at default)
//  CNT_W  8           width of the delivered-select counter
// PORTS
//  clk        in   1      single clock; all state changes on the rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      upstream has an index
//  in_ready   out  1      block can accept; transfer = in_valid & in_ready
//  in_idx     in   SEL_W  index to decode
//  in_en      in   1      0 = decode to all-zero (the encoder's invalid case)
//  out_valid  out  1      out_onehot/out_zero are valid
//  out_ready  in   1      downstream accepts; transfer = out_valid & out_ready
//  out_onehot out  OUT_W  one-hot select, or all-zero when the entry had en=0
//  out_zero   out  1      1 when the entry was decoded with en=0
//  dec_cnt    out  CNT_W  count of delivered entries with out_zero=0
//  cnt_clr    in   1      synchronous clear of dec_cnt
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, out_onehot=0, out_zero=0,
//    dec_cnt=0, in_ready=1, FSM=EMPTY, skid entry invalid.
//  - Decode: onehot = in_en ? (1<<in_idx) : 0; zero = ~in_en.
//    The decode is computed on accept and stored; inputs are not re-sampled.
//  - FSM (occupancy): EMPTY (nothing held), ONE (main reg valid),
//    TWO (main and skid both valid).
//    EMPTY: accept -> ONE.
//    ONE:   accept & !deliver -> TWO; deliver & !accept -> EMPTY;
//           accept & deliver -> ONE (main reloaded with the new entry).
//    TWO:   no accept possible; deliver -> ONE (skid moves to main).
//  - in_ready = (FSM != TWO), driven from a register; no combinational path
//    from out_ready.
//  - Latency: accept in cycle N -> out_valid=1 in cycle N+1 when EMPTY.
//    Throughput is 1 entry/cycle while out_ready=1.
//  - Stall: while out_valid & !out_ready, out_onehot and out_zero stay stable,
//    and out_valid stays high until delivered.
//  - Order: entries leave strictly in accept order; nothing is dropped or
//    duplicated.
//  - Invalid idx is impossible by width. en=0 entries pass as normal entries
//    with zero=1.
//  - dec_cnt: +1 on each deliver with out_zero=0; saturates at 2^CNT_W-1
//    (no wrap). cnt_clr in the same cycle as an increment -> 0 (clear wins).
//  - Reset mid-stream: all held entries are discarded at once; out_valid
//    drops asynchronously.
// STRUCTURE
//  - Shared package: the FSM state encoding
//    (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2) and the default SEL_W/CNT_W
//    localparams shared with the encoder.
//  - One sub-module: stream_skid_buf (parameter DATA_W; holds main/skid regs,
//    the FSM and in_ready). The top level holds the decode function, the
//    payload packing {zero,onehot} and dec_cnt.
// TESTING
//  1 Reset, then idx=0..7, en=1, out_ready=1 every cycle
//    -> out_onehot 01,02,..,80 on cycles 1..8; dec_cnt=8.
//  2 idx=5, en=0 -> out_onehot=00, out_zero=1; dec_cnt unchanged.
//  3 out_ready=0, push idx=2,3 -> in_ready=0 after 2nd accept; output holds 04.
//    Then out_ready=1 -> 04 then 08, in order.
//  4 CNT_W=2, deliver 5 non-zero entries -> dec_cnt=3 (saturated);
//    cnt_clr with a deliver in the same cycle -> 0.
//  5 Hold state TWO, pulse rst_n=0 mid-cycle -> out_valid=0 immediately;
//    after release, in_ready=1 and no stale entry emerges.
//  6 Random valid/ready over 10k cycles -> scoreboard matches
//    1<<idx per entry, in order.

Source files
------------

// File: rtl/decoder_3to8_stream_pkg.sv
// Shared types for the index decoder stream.
// Holds the occupancy FSM encoding and default widths.
package decoder_3to8_stream_pkg;

  localparam int SEL_W_DEF = 3;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer (main + skid) with valid/ready on both sides.
// Ports: clk, rst_n, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module stream_skid_buf
  import decoder_3to8_stream_pkg::*;
#(
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  occ_e              state;
  occ_e              state_nx;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              load_main;
  logic              load_skid;
  logic              main_from_skid;
  logic              accept;
  logic              deliver;

  assign accept    = in_valid & in_ready;
  assign out_valid = (state != ST_EMPTY);
  assign deliver   = out_valid & out_ready;
  assign out_data  = main_q;

  always_comb begin
    state_nx       = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nx  = ST_ONE;
          load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !deliver) begin
          state_nx  = ST_TWO;
          load_skid = 1'b1;
        end else if (deliver && !accept) begin
          state_nx = ST_EMPTY;
        end else if (accept && deliver) begin
          load_main = 1'b1;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a deliver can happen
        if (deliver) begin
          state_nx       = ST_ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      state <= state_nx;
      // registered ready: no path from out_ready
      in_ready <= (state_nx != ST_TWO);
      if (load_main) begin
        main_q <= in_data;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/decoder_3to8_stream.sv
// Registered index-to-one-hot decoder with valid/ready streams.
// Ports: in_* (idx, en), out_* (onehot, zero), dec_cnt, cnt_clr.
module decoder_3to8_stream
  import decoder_3to8_stream_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       in_idx,
  input  logic                   in_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(1<<SEL_W)-1:0]  out_onehot,
  output logic                   out_zero,
  output logic [CNT_W-1:0]       dec_cnt,
  input  logic                   cnt_clr
);

  localparam int OUT_W = 1 << SEL_W;
  localparam int DATA_W = OUT_W + 1;

  function automatic logic [OUT_W-1:0] decode(
    input logic [SEL_W-1:0] idx,
    input logic             en
  );
    logic [OUT_W-1:0] oh;
    oh = '0;
    if (en) begin
      oh[idx] = 1'b1;
    end
    return oh;
  endfunction

  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] out_data;
  logic              deliver_sel;

  // payload is {zero, onehot}, decoded once at accept time
  assign in_data    = {~in_en, decode(in_idx, in_en)};
  assign out_zero   = out_data[OUT_W];
  assign out_onehot = out_data[OUT_W-1:0];

  stream_skid_buf #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  assign deliver_sel = out_valid & out_ready & ~out_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt <= '0;
    end else if (cnt_clr) begin
      dec_cnt <= '0;
    end else if (deliver_sel && (dec_cnt != '1)) begin
      dec_cnt <= dec_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decoder_3to8_stream.sv
// Directed and scoreboarded bench for decoder_3to8_stream.
// Second instance uses CNT_W=2 to exercise counter saturation.
module tb_decoder_3to8_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_idx;
  logic       in_en;
  logic       out_ready;
  logic       cnt_clr;
  logic       cnt_clr2;

  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_onehot;
  logic       out_zero;
  logic [7:0] dec_cnt;

  logic       in_ready2;
  logic       out_valid2;
  logic [7:0] out_onehot2;
  logic       out_zero2;
  logic [1:0] dec_cnt2;

  int n_checks = 0;
  int n_fail = 0;

  logic [8:0] sb[$];

  always #5 clk = ~clk;

  decoder_3to8_stream dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .in_en(in_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .out_zero(out_zero),
    .dec_cnt(dec_cnt), .cnt_clr(cnt_clr)
  );

  decoder_3to8_stream #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_idx(in_idx), .in_en(in_en),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_onehot(out_onehot2), .out_zero(out_zero2),
    .dec_cnt(dec_cnt2), .cnt_clr(cnt_clr2)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [8:0] model(input logic [2:0] idx,
                                       input logic en);
    return en ? (9'd1 << idx) : 9'h100;
  endfunction

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_idx = '0;
    in_en = 1'b0;
    out_ready = 1'b0;
    cnt_clr = 1'b0;
    cnt_clr2 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_onehot", 32'(out_onehot), 32'd0);
    check("rst_zero", 32'(out_zero), 32'd0);
    check("rst_cnt", 32'(dec_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // 1: stream idx 0..7 at full rate
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_idx = 3'(i);
      tick();
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_onehot", 32'(out_onehot), 32'd1 << i);
    end
    in_valid = 1'b0;
    tick();
    check("t1_drained", 32'(out_valid), 32'd0);
    check("t1_cnt", 32'(dec_cnt), 32'd8);

    // 2: en=0 decodes to zero and does not count
    in_valid = 1'b1;
    in_idx = 3'd5;
    in_en = 1'b0;
    tick();
    check("t2_onehot", 32'(out_onehot), 32'd0);
    check("t2_zero", 32'(out_zero), 32'd1);
    in_valid = 1'b0;
    tick();
    check("t2_cnt", 32'(dec_cnt), 32'd8);

    // 3: backpressure fills both entries
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_en = 1'b1;
    in_idx = 3'd2;
    tick();
    check("t3_ready1", 32'(in_ready), 32'd1);
    check("t3_hold1", 32'(out_onehot), 32'h04);
    in_idx = 3'd3;
    tick();
    check("t3_ready2", 32'(in_ready), 32'd0);
    check("t3_hold2", 32'(out_onehot), 32'h04);
    in_valid = 1'b0;
    tick();
    check("t3_stall_valid", 32'(out_valid), 32'd1);
    check("t3_stall_oh", 32'(out_onehot), 32'h04);
    out_ready = 1'b1;
    tick();
    check("t3_second", 32'(out_onehot), 32'h08);
    check("t3_ready3", 32'(in_ready), 32'd1);
    tick();
    check("t3_empty", 32'(out_valid), 32'd0);
    check("t3_cnt", 32'(dec_cnt), 32'd10);

    // 4: 2-bit counter saturates, clear wins over increment
    cnt_clr2 = 1'b1;
    tick();
    cnt_clr2 = 1'b0;
    check("t4_clr", 32'(dec_cnt2), 32'd0);
    in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_idx = 3'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("t4_sat", 32'(dec_cnt2), 32'd3);
    in_valid = 1'b1;
    in_idx = 3'd6;
    tick();
    in_valid = 1'b0;
    cnt_clr2 = 1'b1;
    tick();
    cnt_clr2 = 1'b0;
    check("t4_clr_wins", 32'(dec_cnt2), 32'd0);
    check("t4_cnt8", 32'(dec_cnt), 32'd16);

    // 5: async reset while holding two entries
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_idx = 3'd1;
    tick();
    in_idx = 3'd4;
    tick();
    in_valid = 1'b0;
    check("t5_two", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'd0);
    check("t5_async_oh", 32'(out_onehot), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_stale", 32'(out_valid), 32'd0);
      check("t5_ready", 32'(in_ready), 32'd1);
    end
    check("t5_cnt", 32'(dec_cnt), 32'd0);

    // 6: random handshakes against a scoreboard
    for (int c = 0; c < 10000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_idx = 3'($urandom);
      in_en = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("t6_spurious", 32'(out_valid), 32'd0);
        end else begin
          check("t6_data", 32'({out_zero, out_onehot}),
                32'(sb.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_idx, in_en));
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("t6_extra", 32'(out_valid), 32'd0);
        end else begin
          check("t6_drain", 32'({out_zero, out_onehot}),
                32'(sb.pop_front()));
        end
      end
      tick();
    end
    check("t6_left", 32'(sb.size()), 32'd0);
    check("t6_idle", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
